// File: rtl/alu_resp_packer.sv
// ALU response packer: serialises a completed ALU result into a
// byte packet (opcode, flags, length, payload) for a UART transmitter.
module alu_resp_packer #(
  parameter int DATA_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  opcode_i,
  input  logic [32:0] result_i,
  input  logic        result_valid_i,
  output logic        result_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD
  } state_e;

  localparam logic [2:0] LAST_IDX = 3'(3 + DATA_BYTES);
  localparam logic [7:0] PKT_LEN  = 8'(4 + DATA_BYTES);

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  op_q, op_d;
  logic [32:0] res_q, res_d;
  logic [7:0]  byte_sel;
  logic        take;
  logic        fire;

  assign take = result_valid_i && result_ready_o;
  assign fire = tx_valid_o && tx_ready_i;

  // Ready is masked by reset so nothing is accepted while it is held.
  assign result_ready_o = (state_q == IDLE) && !rst;
  assign tx_valid_o     = (state_q != IDLE);
  assign busy_o         = (state_q != IDLE);

  // State, byte index and captured result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      op_q    <= 8'h00;
      res_q   <= 33'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  end

  // Next-state: capture in IDLE, advance one byte per accepted beat.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    op_d    = op_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (take) begin
          op_d    = opcode_i;
          res_d   = result_i;
          idx_d   = 3'd0;
          state_d = HEADER;
        end
      end
      HEADER: begin
        if (fire) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd3) begin
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (fire) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = 3'd0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 3'd0;
      end
    endcase
  end

  // Byte mux; payload index never passes LAST_IDX, so upper bytes stay unsent.
  always_comb begin
    byte_sel = 8'h00;
    case (idx_q)
      3'd0: byte_sel = op_q;
      3'd1: byte_sel = {7'b0, res_q[32]};
      3'd2: byte_sel = PKT_LEN;
      3'd3: byte_sel = 8'h00;
      3'd4: byte_sel = res_q[7:0];
      3'd5: byte_sel = res_q[15:8];
      3'd6: byte_sel = res_q[23:16];
      3'd7: byte_sel = res_q[31:24];
      default: byte_sel = 8'h00;
    endcase
    tx_data_o = tx_valid_o ? byte_sel : 8'h00;
  end

endmodule

// File: tb/tb_alu_resp_packer.sv
// Bench for alu_resp_packer: queue-based packet model with per-cycle
// compare, directed literal packets, and randomized traffic.
module tb_alu_resp_packer;

  typedef logic [7:0] bq_t[$];

  logic        clk;
  logic        rst;
  logic [7:0]  opcode_i;
  logic [32:0] result_i;
  logic        result_valid_i;
  logic        result_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic        busy_o;

  logic [7:0]  b_op;
  logic [32:0] b_res;
  logic        b_val;
  logic        b_rdy;
  logic [7:0]  b_txd;
  logic        b_txv;
  logic        b_txr;
  logic        b_busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rmode = 0;
  int cap_cyc = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got[$];
  int         gcyc[$];

  alu_resp_packer dut (
    .clk(clk), .rst(rst),
    .opcode_i(opcode_i), .result_i(result_i),
    .result_valid_i(result_valid_i), .result_ready_o(result_ready_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o),
    .tx_ready_i(tx_ready_i), .busy_o(busy_o)
  );

  alu_resp_packer #(.DATA_BYTES(2)) dut2 (
    .clk(clk), .rst(rst),
    .opcode_i(b_op), .result_i(b_res),
    .result_valid_i(b_val), .result_ready_o(b_rdy),
    .tx_data_o(b_txd), .tx_valid_o(b_txv),
    .tx_ready_i(b_txr), .busy_o(b_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask

  // Packet as the spec describes it, for a given payload width.
  function automatic void push_pkt(input logic [7:0] op,
                                   input logic [32:0] r, input int nb);
    exp_q.push_back(op);
    exp_q.push_back({7'b0, r[32]});
    exp_q.push_back(8'(4 + nb));
    exp_q.push_back(8'h00);
    for (int i = 0; i < nb; i++) exp_q.push_back(r[8*i +: 8]);
  endfunction

  // Per-cycle compare, then advance the model for the coming edge.
  always begin
    @(negedge clk);
    cyc++;
    if (rst) begin
      exp_q.delete();
      chk("rst_valid", 64'(tx_valid_o), 64'd0);
      chk("rst_data", 64'(tx_data_o), 64'd0);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_ready", 64'(result_ready_o), 64'd0);
    end else begin
      logic ev;
      ev = (exp_q.size() != 0);
      chk("valid", 64'(tx_valid_o), 64'(ev));
      chk("busy", 64'(busy_o), 64'(ev));
      chk("ready", 64'(result_ready_o), 64'(!ev));
      if (ev) chk("data", 64'(tx_data_o), 64'(exp_q[0]));
      else    chk("idle_data", 64'(tx_data_o), 64'd0);
      if (ev && tx_ready_i) begin
        got.push_back(tx_data_o);
        gcyc.push_back(cyc);
        void'(exp_q.pop_front());
      end else if (!ev && result_valid_i) begin
        push_pkt(opcode_i, result_i, 4);
      end
    end
  end

  // Transmitter ready pattern: always, random, or 1,0,0,1 repeating.
  initial begin
    int p;
    p = 0;
    tx_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      p++;
      case (rmode)
        1: tx_ready_i = 1'($urandom_range(0, 1));
        2: tx_ready_i = ((p % 4) == 0) || ((p % 4) == 3);
        default: tx_ready_i = 1'b1;
      endcase
    end
  end

  task automatic send(input logic [7:0] op, input logic [32:0] r);
    int n;
    n = 0;
    opcode_i = op;
    result_i = r;
    result_valid_i = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!result_ready_o && n < 300);
    if (n >= 300) chk("send_timeout", 64'd1, 64'd0);
    cap_cyc = cyc;
    @(posedge clk);
    #1;
    result_valid_i = 1'b0;
    opcode_i = 8'($urandom);
    result_i = {1'($urandom), 32'($urandom)};
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk("drain_timeout", 64'd1, 64'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_log(input string n, input bq_t e);
    chk({n, "_len"}, 64'(got.size()), 64'(e.size()));
    for (int i = 0; i < e.size() && i < got.size(); i++)
      chk(n, 64'(got[i]), 64'(e[i]));
  endtask

  initial begin
    bq_t lit;
    bq_t blog;
    int  n;
    rst = 1'b1;
    opcode_i = 8'h00;
    result_i = 33'd0;
    result_valid_i = 1'b0;
    b_op = 8'h00;
    b_res = 33'd0;
    b_val = 1'b0;
    b_txr = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 64'(result_ready_o), 64'd1);
    chk("busy_after_rst", 64'(busy_o), 64'd0);

    // single add
    rmode = 0;
    got.delete(); gcyc.delete();
    send(8'hAD, 33'h0_1234_5678);
    drain();
    lit = '{8'hAD, 8'h00, 8'h08, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    chk_log("add", lit);
    if (gcyc.size() == 8) begin
      chk("latency", 64'(gcyc[0] - cap_cyc), 64'd1);
      chk("back_to_back", 64'(gcyc[7] - gcyc[0]), 64'd7);
    end else chk("add_count", 64'(gcyc.size()), 64'd8);

    // carry flag
    got.delete(); gcyc.delete();
    send(8'hAC, 33'h1_0000_0001);
    drain();
    lit = '{8'hAC, 8'h01, 8'h08, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
    chk_log("carry", lit);

    // backpressure
    rmode = 2;
    got.delete(); gcyc.delete();
    send(8'hEC, 33'h0_DEAD_BEEF);
    drain();
    lit = '{8'hEC, 8'h00, 8'h08, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    chk_log("bp", lit);
    rmode = 0;

    // busy overlap
    got.delete(); gcyc.delete();
    send(8'hAD, 33'h0_0000_0010);
    send(8'hD1, 33'h0_0000_0003);
    drain();
    lit = '{8'hAD, 8'h00, 8'h08, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00,
            8'hD1, 8'h00, 8'h08, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00};
    chk_log("overlap", lit);
    if (gcyc.size() == 16)
      chk("gap", 64'(gcyc[8] - gcyc[7]), 64'd2);

    // reset mid-packet
    got.delete(); gcyc.delete();
    send(8'hAD, 33'h0_CAFE_F00D);
    n = 0;
    while (got.size() < 5 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("pre_rst_bytes", 64'(got.size()), 64'd5);
    rst = 1'b1;
    #1;
    chk("async_valid", 64'(tx_valid_o), 64'd0);
    chk("async_data", 64'(tx_data_o), 64'd0);
    chk("async_busy", 64'(busy_o), 64'd0);
    chk("async_ready", 64'(result_ready_o), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("ready_rel", 64'(result_ready_o), 64'd1);
    got.delete(); gcyc.delete();
    send(8'hAD, 33'h0_0000_00FF);
    drain();
    lit = '{8'hAD, 8'h00, 8'h08, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00};
    chk_log("post_rst", lit);

    // randomized traffic, checked per cycle by the model
    for (int k = 0; k < 40; k++) begin
      logic [7:0] op;
      rmode = $urandom_range(0, 2);
      case ($urandom_range(0, 4))
        0: op = 8'hEC;
        1: op = 8'hAD;
        2: op = 8'hAC;
        3: op = 8'hD1;
        default: op = 8'($urandom);
      endcase
      send(op, {1'($urandom), 32'($urandom)});
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    rmode = 0;
    drain();

    // two-byte payload build
    b_op = 8'hEC;
    b_res = 33'h0_ABCD_1234;
    b_val = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (b_txv && b_txr) blog.push_back(b_txd);
      if (b_rdy && b_val) begin
        @(posedge clk);
        #1;
        b_val = 1'b0;
        b_res = 33'h1_FFFF_FFFF;
      end
    end
    got = blog;
    lit = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h34, 8'h12};
    chk_log("db2", lit);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
